sfu_psum_accumulator: RTL and testbench

Special-function-unit stage that sits directly downstream of the output-address mapping stage. It takes a stream of per-column partial-sum vectors tagged with a valid-region flag and a 4-bit output address (o_nij, 0..15), and accumulates them into a 16-entry × COL-column output buffer. At end of pass it applies optional ReLU in place, one entry per cycle, then serves registered reads to the output SRAM writer.

---
 rtl/sfu_pkg.sv | 17 +
 rtl/sfu_sat_add.sv | 34 +++
 rtl/sfu_psum_accumulator.sv | 131 +++++++++++++
 tb/tb_sfu_psum_accumulator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU partial-sum accumulation stage.
//   state_e  : pass sequencing states
//   NUM_OUT  : number of output-buffer entries (one per o_nij)
//   OADDR_BW : width of an output address
package sfu_pkg;

  localparam int unsigned NUM_OUT  = 16;
  localparam int unsigned OADDR_BW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StRelu,
    StDone
  } state_e;

endpackage

// File: rtl/sfu_sat_add.sv
// Single-lane signed saturating adder: sign-extends a PSUM_BW partial sum and
// adds it to an ACC_BW accumulator, clamping to the ACC_BW signed range.
//   acc  : current accumulator value (signed, ACC_BW)
//   psum : incoming partial sum (signed, PSUM_BW)
//   sum  : saturated result (signed, ACC_BW)
module sfu_sat_add #(
  parameter int unsigned PSUM_BW = 16,
  parameter int unsigned ACC_BW  = 20
) (
  input  logic signed [ACC_BW-1:0]  acc,
  input  logic signed [PSUM_BW-1:0] psum,
  output logic signed [ACC_BW-1:0]  sum
);

  localparam int unsigned W = ACC_BW + 1;

  logic [W-1:0] acc_ext;
  logic [W-1:0] psum_ext;
  logic [W-1:0] wide;

  assign acc_ext  = {acc[ACC_BW-1], acc};
  assign psum_ext = {{(W - PSUM_BW){psum[PSUM_BW-1]}}, psum};
  assign wide     = acc_ext + psum_ext;

  // One guard bit is enough: overflow shows up as the top two bits disagreeing,
  // and the top bit then gives the direction to clamp towards.
  always_comb begin
    sum = wide[ACC_BW-1:0];
    if (wide[W-1] != wide[W-2]) begin
      sum = wide[W-1] ? {1'b1, {(ACC_BW - 1){1'b0}}} : {1'b0, {(ACC_BW - 1){1'b1}}};
    end
  end

endmodule

// File: rtl/sfu_psum_accumulator.sv
// Output-stationary partial-sum accumulator with optional in-place ReLU.
//   start/relu_en        : begin a pass (clears the buffer), latch ReLU enable
//   in_valid/in_ready    : input beat handshake, ready only while accumulating
//   in_acc/in_addr       : beat is in the output region / target entry
//   in_psum/in_last      : packed signed lanes / final beat of the pass
//   done                 : buffer is final and readable
//   rd_en/rd_addr        : registered read request (DONE only)
//   rd_valid/rd_data     : read response one cycle later
module sfu_psum_accumulator
  import sfu_pkg::*;
#(
  parameter int unsigned COL     = 8,
  parameter int unsigned PSUM_BW = 16,
  parameter int unsigned ACC_BW  = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_acc,
  input  logic [OADDR_BW-1:0]     in_addr,
  input  logic [COL*PSUM_BW-1:0]  in_psum,
  input  logic                    in_last,
  output logic                    done,
  input  logic                    rd_en,
  input  logic [OADDR_BW-1:0]     rd_addr,
  output logic                    rd_valid,
  output logic [COL*ACC_BW-1:0]   rd_data
);

  state_e                    state_q;
  logic                      relu_q;
  logic [OADDR_BW-1:0]       cnt_q;
  // Flops rather than SRAM so that start can clear every entry in one cycle.
  logic signed [ACC_BW-1:0]  acc_buf_q [NUM_OUT][COL];
  logic signed [ACC_BW-1:0]  sum_lane  [COL];

  // Only one entry is written per beat, so COL adders cover the whole buffer.
  for (genvar i = 0; i < COL; i++) begin : g_lane
    sfu_sat_add #(
      .PSUM_BW(PSUM_BW),
      .ACC_BW (ACC_BW)
    ) u_sat_add (
      .acc (acc_buf_q[in_addr][i]),
      .psum(in_psum[i*PSUM_BW +: PSUM_BW]),
      .sum (sum_lane[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      relu_q   <= 1'b0;
      cnt_q    <= '0;
      in_ready <= 1'b0;
      done     <= 1'b0;
      for (int n = 0; n < NUM_OUT; n++) begin
        for (int i = 0; i < COL; i++) begin
          acc_buf_q[n][i] <= '0;
        end
      end
    end else if (start) begin
      // start overrides everything, including a beat presented this cycle.
      state_q  <= StAccum;
      relu_q   <= relu_en;
      cnt_q    <= '0;
      in_ready <= 1'b1;
      done     <= 1'b0;
      for (int n = 0; n < NUM_OUT; n++) begin
        for (int i = 0; i < COL; i++) begin
          acc_buf_q[n][i] <= '0;
        end
      end
    end else begin
      unique case (state_q)
        StAccum: begin
          if (in_valid) begin
            if (in_acc) begin
              for (int i = 0; i < COL; i++) begin
                acc_buf_q[in_addr][i] <= sum_lane[i];
              end
            end
            if (in_last) begin
              in_ready <= 1'b0;
              if (relu_q) begin
                state_q <= StRelu;
              end else begin
                state_q <= StDone;
                done    <= 1'b1;
              end
            end
          end
        end
        StRelu: begin
          for (int i = 0; i < COL; i++) begin
            if (acc_buf_q[cnt_q][i][ACC_BW-1]) begin
              acc_buf_q[cnt_q][i] <= '0;
            end
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == OADDR_BW'(NUM_OUT - 1)) begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StIdle, StDone: begin
        end
        default: begin
        end
      endcase
    end
  end

  // rd_data holds its last value between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en && (state_q == StDone);
      if (rd_en && (state_q == StDone)) begin
        for (int i = 0; i < COL; i++) begin
          rd_data[i*ACC_BW +: ACC_BW] <= acc_buf_q[rd_addr][i];
        end
      end
    end
  end

endmodule

// File: tb/tb_sfu_psum_accumulator.sv
module tb_sfu_psum_accumulator;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int ACC_BW  = 20;
  localparam int NUM     = 16;
  localparam int AccMax  = (1 << (ACC_BW - 1)) - 1;
  localparam int AccMin  = -(1 << (ACC_BW - 1));

  logic                   clk = 1'b0;
  logic                   reset, start, relu_en, in_valid, in_acc, in_last, rd_en;
  logic [3:0]             in_addr, rd_addr;
  logic [COL*PSUM_BW-1:0] in_psum;
  logic                   in_ready, done, rd_valid;
  logic [COL*ACC_BW-1:0]  rd_data;

  // Reference model: plain integer buffer plus "pass open" / "relu" flags.
  int model [NUM][COL];
  int lane_val [COL];
  bit m_open, m_relu;
  int n_checks = 0;
  int n_pass = 0;
  int cnt;

  sfu_psum_accumulator #(
    .COL    (COL),
    .PSUM_BW(PSUM_BW),
    .ACC_BW (ACC_BW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .relu_en (relu_en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_acc  (in_acc),
    .in_addr (in_addr),
    .in_psum (in_psum),
    .in_last (in_last),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_valid(rd_valid),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int sat(input longint v);
    if (v > AccMax) return AccMax;
    if (v < AccMin) return AccMin;
    return int'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < COL; i++) lane_val[i] = int'($urandom_range(65535)) - 32768;
  endtask

  task automatic set_lanes(input int v);
    for (int i = 0; i < COL; i++) lane_val[i] = v;
  endtask

  task automatic drive_psum();
    for (int i = 0; i < COL; i++) in_psum[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(lane_val[i]);
  endtask

  task automatic do_start(input bit relu);
    start   = 1'b1;
    relu_en = relu;
    for (int n = 0; n < NUM; n++)
      for (int i = 0; i < COL; i++) model[n][i] = 0;
    m_open = 1'b1;
    m_relu = relu;
    step();
    start   = 1'b0;
    relu_en = 1'b0;
  endtask

  task automatic beat(input bit acc, input int addr, input bit last);
    in_valid = 1'b1;
    in_acc   = acc;
    in_addr  = 4'(addr);
    in_last  = last;
    drive_psum();
    if (m_open && acc)
      for (int i = 0; i < COL; i++) model[addr][i] = sat(longint'(model[addr][i]) + lane_val[i]);
    if (m_open && last) begin
      m_open = 1'b0;
      if (m_relu)
        for (int n = 0; n < NUM; n++)
          for (int i = 0; i < COL; i++) if (model[n][i] < 0) model[n][i] = 0;
    end
    step();
    in_valid = 1'b0;
    in_acc   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < NUM; a++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      step();
      chk($sformatf("%s_valid_a%0d", tag, a), {63'd0, rd_valid}, 64'sd1);
      for (int i = 0; i < COL; i++)
        chk($sformatf("%s_a%0d_l%0d", tag, a, i), $signed(rd_data[i*ACC_BW +: ACC_BW]),
            64'(model[a][i]));
    end
    rd_en = 1'b0;
    step();
    chk({tag, "_valid_drop"}, {63'd0, rd_valid}, 64'sd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; in_acc = 1'b0;
    in_last = 1'b0; rd_en = 1'b0; in_addr = '0; rd_addr = '0; in_psum = '0;
    m_open = 1'b0; m_relu = 1'b0;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 0);
    chk("rst_done", {63'd0, done}, 0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 0);
    chk("rst_rd_data", 64'(rd_data[63:0]), 0);
    reset = 1'b0;
    step();
    rd_en = 1'b1;
    step();
    chk("idle_rd_ignored", {63'd0, rd_valid}, 0);
    rd_en = 1'b0;

    // Single beat, no ReLU.
    do_start(1'b0);
    chk("single_ready", {63'd0, in_ready}, 1);
    set_lanes(100);
    beat(1'b1, 5, 1'b1);
    chk("single_done", {63'd0, done}, 1);
    chk("single_ready_drop", {63'd0, in_ready}, 0);
    read_all("single");

    // Full 3x3 conv pass with random psums, idle gaps and discarded beats.
    do_start(1'b0);
    for (int kij = 0; kij < 9; kij++) begin
      for (int nij = 0; nij < 16; nij++) begin
        if ($urandom_range(3) == 0) begin
          rand_lanes();
          beat(1'b0, int'($urandom_range(15)), 1'b0);
        end
        if ($urandom_range(4) == 0) step();
        rand_lanes();
        beat(1'b1, nij, (kij == 8) && (nij == 15));
      end
    end
    chk("conv_done", {63'd0, done}, 1);
    read_all("conv");

    // Directed ReLU: lanes -7 / +9 at addr 3, done 16 cycles after the last beat.
    do_start(1'b1);
    for (int i = 0; i < COL; i++) lane_val[i] = (i % 2 == 1) ? 9 : -7;
    beat(1'b1, 3, 1'b1);
    chk("relu_ready_drop", {63'd0, in_ready}, 0);
    cnt = 0;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    chk("relu_latency", 64'(cnt), 16);
    read_all("relu_dir");

    // Random ReLU pass.
    do_start(1'b1);
    for (int k = 0; k < 40; k++) begin
      rand_lanes();
      beat(1'b1, int'($urandom_range(15)), k == 39);
    end
    cnt = 0;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    chk("relu_rand_latency", 64'(cnt), 16);
    read_all("relu_rand");

    // Positive then negative saturation.
    do_start(1'b0);
    set_lanes(32767);
    for (int k = 0; k < 20; k++) beat(1'b1, 0, k == 19);
    rd_en = 1'b1; rd_addr = 4'd0;
    step();
    rd_en = 1'b0;
    chk("sat_pos_const", $signed(rd_data[0 +: ACC_BW]), 64'sd524287);
    read_all("sat_pos");
    do_start(1'b0);
    set_lanes(-32768);
    for (int k = 0; k < 20; k++) beat(1'b1, 0, k == 19);
    rd_en = 1'b1; rd_addr = 4'd0;
    step();
    rd_en = 1'b0;
    chk("sat_neg_const", $signed(rd_data[ACC_BW +: ACC_BW]), -64'sd524288);
    read_all("sat_neg");

    // Abort mid-pass, with a beat colliding with start; rd_en ignored in ACCUM.
    do_start(1'b0);
    rand_lanes();
    beat(1'b1, 2, 1'b0);
    rd_en = 1'b1; rd_addr = 4'd2;
    step();
    chk("accum_rd_ignored", {63'd0, rd_valid}, 0);
    rd_en = 1'b0;
    rand_lanes();
    beat(1'b1, 7, 1'b0);
    set_lanes(1234);
    in_valid = 1'b1; in_acc = 1'b1; in_addr = 4'd7; drive_psum();
    do_start(1'b0);
    in_valid = 1'b0; in_acc = 1'b0;
    chk("abort_ready", {63'd0, in_ready}, 1);
    set_lanes(555);
    beat(1'b0, 7, 1'b1);
    chk("abort_done", {63'd0, done}, 1);
    read_all("abort");

    // Back-to-back beats to the same address.
    do_start(1'b0);
    set_lanes(1);
    for (int k = 0; k < 4; k++) beat(1'b1, 15, k == 3);
    read_all("b2b");
    chk("b2b_const", $signed(rd_data[0 +: ACC_BW]), 64'sd4);

    // Asynchronous reset in the middle of ReLU.
    do_start(1'b1);
    set_lanes(-5);
    beat(1'b1, 3, 1'b1);
    repeat (5) step();
    chk("mid_relu_done", {63'd0, done}, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_in_ready", {63'd0, in_ready}, 0);
    chk("arst_done", {63'd0, done}, 0);
    chk("arst_rd_valid", {63'd0, rd_valid}, 0);
    chk("arst_rd_data", 64'(rd_data[63:0]), 0);
    #3 reset = 1'b0;
    m_open = 1'b0;
    repeat (20) step();
    chk("post_rst_done", {63'd0, done}, 0);
    chk("post_rst_ready", {63'd0, in_ready}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
